// File: rtl/serial_frame_transmitter.sv
// Serializes handshaked parallel words into preamble/payload/gap frames on a
// single registered line, bit-stuffing the payload so 0100 only marks a preamble.
module serial_frame_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic                  data_serial,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  frame_done
);

  // state    | meaning
  // IDLE     | line idle high, ready for a word
  // PREAMBLE | line carries preamble bit PREAMBLE_BITS[cnt]
  // PAYLOAD  | line carries a payload or stuffed bit; cnt = real bits still to send
  // GAP      | line carries idle gap bit; cnt = gap bits still to send
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;

  localparam int         CW            = $clog2(DATA_WIDTH + GAP_BITS + 1);
  localparam logic [3:0] PREAMBLE_BITS = 4'b0100;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [2:0]            hist, hist_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  serial_n, valid_n, done_n;
  logic                  stuff, pay_bit;
  logic [DATA_WIDTH-1:0] pay_shreg;
  logic [CW-1:0]         pay_rem, pay_cnt;

  assign data_in_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  // Outputs are registered, so next-cycle line bit is decided one edge ahead.
  always_comb begin
    pay_rem   = (state == PAYLOAD) ? cnt : CW'(DATA_WIDTH);
    stuff     = (hist == 3'b010) && !shreg[DATA_WIDTH-1];
    pay_bit   = stuff ? 1'b1 : shreg[DATA_WIDTH-1];
    pay_shreg = stuff ? shreg : (shreg << 1);
    pay_cnt   = stuff ? pay_rem : (pay_rem - CW'(1));

    state_n  = state;
    shreg_n  = shreg;
    hist_n   = hist;
    cnt_n    = cnt;
    serial_n = 1'b1;
    valid_n  = 1'b0;
    done_n   = 1'b0;

    case (state)
      IDLE: begin
        if (data_in_valid) begin
          state_n  = PREAMBLE;
          shreg_n  = data_in;
          cnt_n    = CW'(3);
          serial_n = PREAMBLE_BITS[3];
          valid_n  = 1'b1;
          hist_n   = {2'b00, PREAMBLE_BITS[3]};
        end
      end
      PREAMBLE: begin
        valid_n = 1'b1;
        if (cnt != '0) begin
          cnt_n    = cnt - CW'(1);
          serial_n = PREAMBLE_BITS[cnt[1:0] - 2'd1];
          hist_n   = {hist[1:0], PREAMBLE_BITS[cnt[1:0] - 2'd1]};
        end else begin
          state_n  = PAYLOAD;
          serial_n = pay_bit;
          shreg_n  = pay_shreg;
          cnt_n    = pay_cnt;
          hist_n   = {hist[1:0], pay_bit};
        end
      end
      PAYLOAD: begin
        valid_n = 1'b1;
        if (cnt != '0) begin
          serial_n = pay_bit;
          shreg_n  = pay_shreg;
          cnt_n    = pay_cnt;
          hist_n   = {hist[1:0], pay_bit};
        end else begin
          state_n = GAP;
          cnt_n   = CW'(GAP_BITS - 1);
          hist_n  = {hist[1:0], 1'b1};
        end
      end
      GAP: begin
        if (cnt != '0) begin
          valid_n = 1'b1;
          cnt_n   = cnt - CW'(1);
          done_n  = (cnt == CW'(1));
          hist_n  = {hist[1:0], 1'b1};
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      hist        <= '0;
      cnt         <= '0;
      data_serial <= 1'b1;
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      hist        <= hist_n;
      cnt         <= cnt_n;
      data_serial <= serial_n;
      data_valid  <= valid_n;
      frame_done  <= done_n;
    end
  end

endmodule
